// File: rtl/board_display_ctrl_pkg.sv
// board_display_ctrl_pkg: shared board/tile constants, VGA blanking limits and FSM encoding
package board_display_ctrl_pkg;
  localparam int TW = 4;
  localparam int NTILES = 16;
  localparam int BW = TW * NTILES;
  localparam logic [9:0] VBP = 10'd31;
  localparam logic [9:0] VFP = 10'd511;
  localparam logic [3:0] FLASH_FRAMES = 4'd8;
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  function automatic logic [3:0] tile_idx(input logic [1:0] y, input logic [1:0] x);
    return {y, x};
  endfunction
endpackage

// File: rtl/board_display_ctrl_vblank_timer.sv
// vblank_timer: registered vertical-blanking flag and start-of-blanking frame pulse from hc/vc
module vblank_timer
  import board_display_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic       in_blank_r,
  output logic       frame_tick
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_blank_r <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      in_blank_r <= (vc < VBP) || (vc >= VFP);
      frame_tick <= (vc == VFP) && (hc == 10'd0);
    end
endmodule

// File: rtl/board_display_ctrl.sv
// board_display_ctrl: buffers a board snapshot and commits it tile-by-tile during vertical blanking
// Optional TILE_FLASH_EN adds a per-tile changed flag that expires after FLASH_FRAMES frames.
module board_display_ctrl
  import board_display_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              upd_valid,
  input  logic [BW-1:0]     upd_board,
  output logic              upd_ready,
  output logic [BW-1:0]     tile_vals,
  output logic              frame_tick,
  output logic              commit_done,
  output logic [NTILES-1:0] flash_mask
);
  state_t state, state_n;
  logic [BW-1:0] pending;
  logic [3:0] idx;
  logic in_blank_r, accept, wr, last, ready_d;
  vblank_timer u_vbt (.clk(clk), .rst(rst), .hc(hc), .vc(vc), .in_blank_r(in_blank_r), .frame_tick(frame_tick));
  assign accept = upd_valid && upd_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE)    ? (accept ? PENDING : IDLE) :
              (state == PENDING) ? (in_blank_r ? COMMIT : PENDING) :
              (last ? IDLE : COMMIT);
  // ready is held low through the commit_done cycle, so it decodes the next state minus the last write
  always_comb begin
    wr = state == COMMIT;
    last = wr && (idx == 4'd15);
    ready_d = (state_n == IDLE) && !last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      idx <= 4'd0;
      tile_vals <= '0;
      upd_ready <= 1'b1;
      commit_done <= 1'b0;
    end else begin
      upd_ready <= ready_d;
      commit_done <= last;
      if (accept) pending <= upd_board;
      if (wr) begin
        tile_vals[idx*TW +: TW] <= pending[idx*TW +: TW];
        idx <= idx + 4'd1;
      end else idx <= 4'd0;
    end
`ifdef TILE_FLASH_EN
  logic [3:0] fcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fcnt <= 4'd0;
      flash_mask <= '0;
    end else begin
      if (commit_done) fcnt <= FLASH_FRAMES;
      else if (frame_tick && fcnt != 4'd0) fcnt <= fcnt - 4'd1;
      if (wr) flash_mask[idx] <= (pending[idx*TW +: TW] != tile_vals[idx*TW +: TW]) && (pending[idx*TW +: TW] != 4'd0);
      else if (frame_tick && fcnt == 4'd1) flash_mask <= '0;
    end
`else
  assign flash_mask = '0;
`endif
endmodule

// File: tb/tb_board_display_ctrl.sv
// tb_board_display_ctrl: table-driven commit timing checks with a snapshot scoreboard
module tb_board_display_ctrl;
  import board_display_ctrl_pkg::*;
  localparam logic [9:0] HLAST = 10'd3;
  localparam logic [9:0] VLAST = 10'd524;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] hc = 10'd0, vc = 10'd100;
  logic upd_valid = 1'b0;
  logic [63:0] upd_board = '0;
  logic upd_ready, frame_tick, commit_done;
  logic [63:0] tile_vals;
  logic [15:0] flash_mask;
  board_display_ctrl dut (.clk(clk), .rst(rst), .hc(hc), .vc(vc), .upd_valid(upd_valid),
    .upd_board(upd_board), .upd_ready(upd_ready), .tile_vals(tile_vals),
    .frame_tick(frame_tick), .commit_done(commit_done), .flash_mask(flash_mask));
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0, ft_err = 0, ft_seen = 0, fl_err = 0, done_seen = 0;
  bit accepted;
  logic [63:0] sb[$];
  logic [63:0] cur = '0;
  typedef struct {logic [9:0] v0; logic [63:0] board; int lat;} vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic jump(input logic [9:0] v);
    vc = v;
    hc = 10'd0;
  endtask

  task automatic step();
    bit a;
    a = upd_valid && upd_ready;
    if (a) sb.push_back(upd_board);
    @(posedge clk);
    #1;
    accepted = a;
    if (frame_tick !== (vc == VFP && hc == 10'd0)) ft_err++;
    if (frame_tick === 1'b1) ft_seen++;
`ifndef TILE_FLASH_EN
    if (flash_mask !== 16'h0) fl_err++;
`endif
    if (commit_done === 1'b1) begin
      done_seen++;
      check("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) check("scoreboard", tile_vals, sb.pop_front());
    end
    if (hc == HLAST) begin
      hc = 10'd0;
      vc = (vc == VLAST) ? 10'd0 : vc + 10'd1;
    end else hc = hc + 10'd1;
  endtask

  function automatic logic [63:0] mix(input logic [63:0] o, input logic [63:0] n, input int w);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 16; i++) if (i < w) r[i*4 +: 4] = n[i*4 +: 4];
    return r;
  endfunction

  task automatic offer(input logic [9:0] v0, input logic [63:0] b, input int lat);
    logic [63:0] old;
    int k, bad;
    old = cur;
    jump(v0);
    upd_board = b;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    check("accept", 64'(accepted), 64'd1);
    check("ready_drop", 64'(upd_ready), 64'd0);
    k = 1;
    bad = 0;
    forever begin
      if (tile_vals !== mix(old, b, k - lat + 16) || upd_ready !== 1'b0) bad++;
      if (commit_done === 1'b1 || k >= lat + 8) break;
      step();
      k++;
    end
    check("commit_latency", 64'(k), 64'(lat));
    check("commit_progress", 64'(bad), 64'd0);
    step();
    check("ready_rise", 64'(upd_ready), 64'd1);
    check("done_pulse", 64'(commit_done), 64'd0);
    cur = b;
  endtask

  initial begin
    logic [63:0] b0, ba, bb, bc;
    int a_done, b_done, acc_k, d0, n;
    b0 = '0;
    b0[tile_idx(2'd0, 2'd0)*4 +: 4] = 4'd1;
    b0[tile_idx(2'd1, 2'd1)*4 +: 4] = 4'd11;
    vecs[0] = '{10'd100, b0, 1662};
    vecs[1] = '{10'd5, 64'hFEDC_BA98_7654_3210, 18};
    vecs[2] = '{10'd510, 64'h0F0E_0000_1234_0000, 22};
    vecs[3] = '{10'd30, 64'h1111_2222_3333_4444, 18};
    vecs[4] = '{10'd31, 64'h0, 1938};
    vecs[5] = '{10'd520, 64'hEEEE_FFFF_0000_0001, 18};
    repeat (3) step();
    check("rst_tile_vals", tile_vals, 64'h0);
    check("rst_ready", 64'(upd_ready), 64'd1);
    check("rst_frame_tick", 64'(frame_tick), 64'd0);
    check("rst_commit_done", 64'(commit_done), 64'd0);
    check("rst_flash", 64'(flash_mask), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].v0, vecs[i].board, vecs[i].lat);
      if (i == 0) begin
        check("tile0", 64'(tile_vals[3:0]), 64'd1);
        check("tile5", 64'(tile_vals[23:20]), 64'd11);
        check("others_zero", tile_vals & ~64'h0000_0000_00F0_000F, 64'h0);
      end
    end
    ba = 64'h1234_5678_9ABC_DEF0;
    bb = 64'h0102_0304_0506_0708;
    jump(10'd500);
    upd_board = ba;
    upd_valid = 1'b1;
    step();
    check("held_accept_a", 64'(accepted), 64'd1);
    upd_board = bb;
    a_done = 0;
    b_done = 0;
    acc_k = 0;
    for (int k = 2; k <= 120 && b_done == 0; k++) begin
      step();
      if (accepted && acc_k == 0) begin
        acc_k = k;
        upd_valid = 1'b0;
      end
      if (commit_done === 1'b1) begin
        if (a_done == 0) a_done = k;
        else b_done = k;
      end
    end
    upd_valid = 1'b0;
    check("held_a_done", 64'(a_done), 64'd62);
    check("held_b_accept", 64'(acc_k), 64'd64);
    check("held_b_done", 64'(b_done), 64'd81);
    check("held_final", tile_vals, bb);
    cur = bb;
    step();
    bc = 64'hAAAA_5555_AAAA_5555;
    jump(10'd500);
    upd_board = bc;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    for (int k = 2; k <= 53; k++) step();
    check("partial_idx7", tile_vals, mix(cur, bc, 7));
    rst = 1'b1;
    #1;
    check("mid_rst_tile_vals", tile_vals, 64'h0);
    check("mid_rst_ready", 64'(upd_ready), 64'd1);
    check("mid_rst_done", 64'(commit_done), 64'd0);
    sb.delete();
    cur = '0;
    d0 = done_seen;
    step();
    step();
    rst = 1'b0;
    repeat (30) step();
    check("no_done_after_rst", 64'(done_seen), 64'(d0));
    check("ready_after_rst", 64'(upd_ready), 64'd1);
    offer(10'd5, 64'h0000_DCBA_0000_0987, 18);
    jump(10'd0);
    ft_seen = 0;
    repeat (6300) step();
    check("frame_ticks_3", 64'(ft_seen), 64'd3);
`ifdef TILE_FLASH_EN
    offer(10'd5, 64'h0000_0000_0003_0000, 18);
    offer(10'd5, 64'h0000_0070_0003_0500, 18);
    check("flash_after_commit", 64'(flash_mask), 64'h0204);
    n = 0;
    for (int c = 0; c < 20000 && n < 8; c++) begin
      step();
      if (frame_tick === 1'b1) n++;
    end
    check("flash_ticks", 64'(n), 64'd8);
    check("flash_hold", 64'(flash_mask), 64'h0204);
    step();
    check("flash_clear", 64'(flash_mask), 64'h0);
`else
    check("flash_zero", 64'(fl_err), 64'd0);
`endif
    check("frame_tick_timing", 64'(ft_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
